// File: rtl/inert_pkg.sv
// Shared types and constants for the raw-inertial-data reader: state encoding,
// sensor configuration writes and the burst-read address map.
package inert_pkg;

    typedef enum logic [2:0] {SETTLE, CFG, WAIT_INT, READ, VLD} inert_rd_state_t;

    localparam logic [15:0] CFG_INT_EN = 16'h0D02;  // INT on data-ready
    localparam logic [15:0] CFG_ACCEL  = 16'h1053;  // accel 208 Hz, 2 g
    localparam logic [15:0] CFG_GYRO   = 16'h1150;  // gyro 208 Hz, 245 dps
    localparam logic [15:0] CFG_ROUND  = 16'h1460;  // rounding on
    localparam int          CFG_CNT    = 4;

    localparam logic [7:0]  RD_BASE    = 8'hA2;
    localparam int          RD_CNT     = 10;

    function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CFG_INT_EN;
            2'd1:    return CFG_ACCEL;
            2'd2:    return CFG_GYRO;
            default: return CFG_ROUND;
        endcase
    endfunction

    function automatic logic [15:0] rd_cmd(input logic [3:0] idx);
        return {RD_BASE + {4'h0, idx}, 8'h00};
    endfunction

endpackage

// File: rtl/inert_reader_if.sv
// Handshake between the inertial reader and the SPI monarch.
interface inert_reader_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] inert_data;

    modport master (output wrt, cmd, input done, inert_data);
    modport slave  (input wrt, cmd, output done, inert_data);
endinterface

// File: rtl/inert_reader.sv
// Configures the inertial sensor after reset, then on each data-ready interrupt
// burst-reads ten bytes and publishes five signed words with a vld strobe.
module inert_reader
    import inert_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  INT,
    inert_reader_if.master        spi,
    output logic                  init_done,
    output logic                  vld,
    output logic [15:0]           ptch_rt,
    output logic [15:0]           roll_rt,
    output logic [15:0]           yaw_rt,
    output logic [15:0]           ax,
    output logic [15:0]           ay
);

    localparam int         TMR_W    = FAST_SIM ? 9 : 16;
    localparam logic [3:0] CFG_LAST = 4'(CFG_CNT - 1);
    localparam logic [3:0] RD_LAST  = 4'(RD_CNT - 1);

    inert_rd_state_t           state_q, state_d;
    logic [TMR_W-1:0]          tmr_q, tmr_d;
    logic [3:0]                idx_q, idx_d;
    logic                      busy_q, busy_d;
    logic                      wrt_q, wrt_d;
    logic [15:0]               cmd_q, cmd_d;
    logic                      init_q, init_d;
    logic                      vld_q, vld_d;
    logic [RD_CNT-1:0][7:0]    hold_q, hold_d;
    logic [4:0][15:0]          words_q, words_d;
    logic                      int_meta_q, int_sync_q;
    logic                      done_ok;
    logic                      unused_data_hi;

    // A done with nothing outstanding must not advance the sequence.
    assign done_ok        = spi.done && busy_q;
    assign unused_data_hi = ^spi.inert_data[15:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SETTLE;
            tmr_q      <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            wrt_q      <= 1'b0;
            cmd_q      <= '0;
            init_q     <= 1'b0;
            vld_q      <= 1'b0;
            hold_q     <= '0;
            words_q    <= '0;
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            wrt_q      <= wrt_d;
            cmd_q      <= cmd_d;
            init_q     <= init_d;
            vld_q      <= vld_d;
            hold_q     <= hold_d;
            words_q    <= words_d;
            int_meta_q <= INT;
            int_sync_q <= int_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SETTLE:   if (&tmr_q) state_d = CFG;
            CFG:      if (done_ok && idx_q == CFG_LAST) state_d = WAIT_INT;
            WAIT_INT: if (int_sync_q) state_d = READ;
            READ:     if (done_ok && idx_q == RD_LAST) state_d = VLD;
            VLD:      state_d = WAIT_INT;
            default:  state_d = SETTLE;
        endcase
    end

    // Each transaction is launched on the same edge that ends the previous one,
    // so wrt lands in the cycle right after done.
    always_comb begin
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        init_d  = init_q;
        vld_d   = 1'b0;
        hold_d  = hold_q;
        words_d = words_q;
        case (state_q)
            SETTLE: begin
                tmr_d = tmr_q + 1'b1;
                if (state_d == CFG) begin
                    idx_d  = '0;
                    wrt_d  = 1'b1;
                    cmd_d  = cfg_cmd(2'd0);
                    busy_d = 1'b1;
                end
            end
            CFG: begin
                if (done_ok) begin
                    idx_d = idx_q + 4'd1;
                    if (state_d == WAIT_INT) begin
                        busy_d = 1'b0;
                        init_d = 1'b1;
                    end else begin
                        wrt_d = 1'b1;
                        cmd_d = cfg_cmd(idx_q[1:0] + 2'd1);
                    end
                end
            end
            WAIT_INT: begin
                if (state_d == READ) begin
                    idx_d  = '0;
                    wrt_d  = 1'b1;
                    cmd_d  = rd_cmd(4'd0);
                    busy_d = 1'b1;
                end
            end
            READ: begin
                if (done_ok) begin
                    hold_d[idx_q] = spi.inert_data[7:0];
                    idx_d         = idx_q + 4'd1;
                    if (state_d == VLD) begin
                        // Words load from hold_d so the final byte joins the set on this edge.
                        busy_d = 1'b0;
                        vld_d  = 1'b1;
                        for (int k = 0; k < 5; k++)
                            words_d[k] = {hold_d[2*k+1], hold_d[2*k]};
                    end else begin
                        wrt_d = 1'b1;
                        cmd_d = rd_cmd(idx_q + 4'd1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign spi.wrt   = wrt_q;
    assign spi.cmd   = cmd_q;
    assign init_done = init_q;
    assign vld       = vld_q;
    assign ptch_rt   = words_q[0];
    assign roll_rt   = words_q[1];
    assign yaw_rt    = words_q[2];
    assign ax        = words_q[3];
    assign ay        = words_q[4];

endmodule

// File: doc/inert_reader.md
# inert_reader

Producer side of the raw-inertial-data interface: drives the SPI monarch to configure the inertial sensor after reset, then on every sensor data-ready interrupt reads the ten rate/accel bytes. It assembles them into signed 16-bit words and presents them with a one-cycle `vld` strobe to the downstream integrator. It sits between the SPI monarch and the inertial integrator in the flight-controller datapath.

## Interface
- `FAST_SIM`, 1, shortens the post-reset settle timer (9-bit when 1, 16-bit when 0).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `INT`  in  1  sensor data-ready interrupt, asynchronous to `clk`, level-high.
- `done`  in  1  SPI monarch transaction complete, one-cycle pulse.
- `inert_data`  in  16  SPI monarch read word; only `[7:0]` is used.
- `wrt`  out  1  start SPI transaction, one-cycle pulse.
- `cmd`  out  16  SPI command word, held stable from `wrt` until `done`.
- `init_done`  out  1  high once configuration writes are complete; stays high until reset.
- `vld`  out  1  new sample set valid, one-cycle pulse.
- `ptch_rt`, `roll_rt`, `yaw_rt`  out  16  signed gyro rates.
- `ax`, `ay`  out  16  signed accelerations.

## Operation
- All outputs reset to 0. Reset at any point, including mid-transaction, returns the block to SETTLE and zeroes every output.
- SETTLE: a free-running timer counts from 0. At all-ones it moves to CFG.
- CFG: issues four writes in order: 0x0D02 (enable INT on data-ready), 0x1053 (accel 208 Hz, 2 g), 0x1150 (gyro 208 Hz, 245 dps), 0x1460 (rounding on).
  - After the `done` of the fourth write, `init_done` sets and the block moves to WAIT_INT.
- `INT` passes through a two-flop synchronizer. WAIT_INT leaves on synchronized `INT` = 1 and enters READ.
- READ: ten reads issued in order. The command is `{addr, 8'h00}` with addr 0xA2 through 0xAB, giving pitch L/H, roll L/H, yaw L/H, ax L/H, ay L/H.
  - On each `done`, `inert_data[7:0]` is captured into the holding byte for the current index.
  - A 4-bit index counter selects both the command and the holding byte. It clears on entry to CFG and READ.
- VLD: all five output words load simultaneously from the holding bytes as `{H,L}`. `vld` pulses, then the block returns to WAIT_INT.
  - Outputs hold their values between `vld` pulses; a partially read set never appears on the outputs.
- `INT` while in SETTLE, CFG or READ is ignored. If `INT` is still high on return to WAIT_INT, a new READ starts. The sensor clears `INT` when its data is read.
- A `done` pulse with no transaction outstanding is ignored.

## Timing
- `wrt` is high for exactly one cycle: the first cycle a transaction's `cmd` is valid.
- The next transaction's `wrt` is asserted the cycle after the previous `done`.
- `cmd` changes only in the cycle `wrt` asserts.
- `init_done` rises the cycle after the fourth CFG `done`.
- `vld` and the output update occur together, one cycle after the tenth READ `done`.
- INT-to-first-`wrt` latency is 3 cycles: 2 synchronizer cycles plus 1 state transition.
- Settle time is 2^9 cycles with `FAST_SIM` = 1 and 2^16 cycles with `FAST_SIM` = 0.

## Structure
- Shared package `inert_pkg` holds:
  - the state enum `inert_rd_state_t` {SETTLE, CFG, WAIT_INT, READ, VLD};
  - the four config command constants;
  - the read base address 0xA2 and read count 10.
- Single module with no sub-modules. The SPI monarch is instantiated beside this block at the next level up.

## Test plan
- Reset release, `FAST_SIM` = 1 → exactly four `wrt` pulses with `cmd` 0x0D02, 0x1053, 0x1150, 0x1460. `init_done` = 1 one cycle after the fourth `done`. `vld` and `wrt` stay 0 until `INT`.
- After init, raise `INT`; monarch model returns bytes 0x34,0x12, 0xCD,0xAB, 0x01,0x00, 0xFF,0xFF, 0x00,0x80 → one `vld` pulse with `ptch_rt` = 0x1234, `roll_rt` = 0xABCD, `yaw_rt` = 0x0001, `ax` = 0xFFFF, `ay` = 0x8000. Commands 0xA200 through 0xAB00 appear in order.
- Pulse `INT` during CFG and during the fifth read → no extra transaction and no early `vld`. The outputs keep their prior set until the tenth `done`.
- Hold `INT` high across two sequences → two back-to-back READ sequences and two `vld` pulses, with the second set loaded correctly.
- Assert `rst` between the sixth `wrt` and its `done` → all outputs 0 immediately. The block restarts from SETTLE and re-issues the four config writes.
- Inject a stray `done` in WAIT_INT → no state change, no capture, no `wrt`.
